// File: rtl/relm_div_seq.sv
// relm_div_seq: sequencer for the custom divide datapath.
// Walks DIV -> DIVINIT -> DIVLOOP* -> DIVMOD to form an unsigned WD-bit
// quotient and remainder. It owns the accumulator and {D,C,B} state and
// feeds them to the custom unit. Each cycle it registers the unit's
// next-state values. Divide-by-zero bypasses the unit entirely.
module relm_div_seq #(
    parameter int WD  = 32,
    parameter int WOP = 5,
    parameter int WC  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_in,
    output logic               ready_out,
    input  logic [WD-1:0]      n_in,
    input  logic [WD-1:0]      den_in,
    output logic               valid_out,
    input  logic               ack_in,
    output logic [WD-1:0]      q_out,
    output logic [WD-1:0]      r_out,
    output logic [WOP-1:0]     op_out,
    output logic               opb_out,
    output logic [WD-1:0]      x_out,
    output logic [WD-1:0]      xb_out,
    output logic [WD-1:0]      a_out,
    output logic [WC+WD-1:0]   cb_out,
    input  logic [WD-1:0]      a_in,
    input  logic [WC+WD-1:0]   cb_in,
    input  logic [WD-1:0]      mul_a_in,
    input  logic [WD-1:0]      mul_x_in,
    output logic [2*WD-1:0]    mul_ax_out
);

    localparam int WI = $clog2(WD);

    // Opcode presented while any divide sub-op is in flight.
    localparam logic [WOP-1:0] OP_ACTIVE = {{(WOP-3){1'b0}}, 3'b101};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIV  = 3'd1,
        S_INIT = 3'd2,
        S_LOOP = 3'd3,
        S_MOD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               state_r, state_s;
    logic [WD-1:0]        a_r, a_s;
    logic [WC+WD-1:0]     cb_r, cb_s;
    logic [WD-1:0]        xb_r, xb_s;
    logic [WD-1:0]        q_r, q_s;
    logic [WD-1:0]        r_r, r_s;
    logic                 valid_r, valid_s;
    logic                 ready_r, ready_s;
    logic [WOP-1:0]       op_r, op_s;
    logic                 opb_r, opb_s;
    logic [WD-1:0]        x_r, x_s;
    logic [WD-1:0]        b_next_s;

    // Index of the highest set bit; B is one-hot, so this is log2(B).
    function automatic logic [WI-1:0] msb_idx(input logic [WD-1:0] v);
        logic [WI-1:0] idx;
        idx = '0;
        for (int i = 0; i < WD; i++) begin
            if (v[i]) begin
                idx = WI'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // x operand carrying a sub-op selector; all other bits are zero.
    function automatic logic [WD-1:0] subop_x(input logic [1:0] sel);
        logic [WD-1:0] v;
        v = '0;
        v[WOP+1:WOP] = sel;
        return v;
    endfunction

    assign b_next_s = cb_in[WD-1:0];

    // Unsigned product the unit consumes during DIVINIT.
    assign mul_ax_out = (2*WD)'(mul_a_in) * (2*WD)'(mul_x_in);

    // Next-state and next-datapath decode for the divide sequence.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        cb_s    = cb_r;
        xb_s    = xb_r;
        q_s     = q_r;
        r_s     = r_r;
        case (state_r)
            S_IDLE: begin
                if (start_in && ready_r) begin
                    a_s  = n_in;
                    xb_s = den_in;
                    cb_s = '0;
                    if (den_in == {WD{1'b0}}) begin
                        q_s     = {WD{1'b1}};
                        r_s     = n_in;
                        state_s = S_DONE;
                    end else begin
                        state_s = S_DIV;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DIV: begin
                cb_s = cb_in;
                // Align msb(N) against msb(D) to get the leading quotient bit.
                if (a_in >= b_next_s) begin
                    a_s = a_in >> msb_idx(b_next_s);
                end else begin
                    a_s = '0;
                end
                state_s = S_INIT;
            end
            S_INIT: begin
                a_s  = a_in;
                cb_s = cb_in;
                if (a_in != {WD{1'b0}}) begin
                    state_s = S_LOOP;
                end else begin
                    state_s = S_MOD;
                end
            end
            S_LOOP: begin
                a_s  = a_in;
                cb_s = cb_in;
                if (a_in == {WD{1'b0}}) begin
                    state_s = S_MOD;
                end else begin
                    state_s = S_LOOP;
                end
            end
            S_MOD: begin
                q_s     = b_next_s;
                r_s     = a_in;
                state_s = S_DONE;
            end
            S_DONE: begin
                if (ack_in) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Unit command and handshake flags for the state being entered, so the
    // registered outputs line up with the state they describe.
    always_comb begin
        op_s    = '0;
        opb_s   = 1'b0;
        x_s     = '0;
        valid_s = (state_s == S_DONE);
        ready_s = (state_s == S_IDLE);
        case (state_s)
            S_DIV: begin
                op_s  = OP_ACTIVE;
                opb_s = 1'b0;
                x_s   = '0;
            end
            S_INIT: begin
                op_s  = OP_ACTIVE;
                opb_s = 1'b1;
                x_s   = subop_x(2'b01);
            end
            S_LOOP: begin
                op_s  = OP_ACTIVE;
                opb_s = 1'b1;
                x_s   = subop_x(2'b10);
            end
            S_MOD: begin
                op_s  = OP_ACTIVE;
                opb_s = 1'b1;
                x_s   = subop_x(2'b11);
            end
            default: begin
                op_s  = '0;
                opb_s = 1'b0;
                x_s   = '0;
            end
        endcase
    end

    // State, datapath and output registers; reset drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            a_r     <= '0;
            cb_r    <= '0;
            xb_r    <= '0;
            q_r     <= '0;
            r_r     <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            op_r    <= '0;
            opb_r   <= 1'b0;
            x_r     <= '0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            cb_r    <= cb_s;
            xb_r    <= xb_s;
            q_r     <= q_s;
            r_r     <= r_s;
            valid_r <= valid_s;
            ready_r <= ready_s;
            op_r    <= op_s;
            opb_r   <= opb_s;
            x_r     <= x_s;
        end
    end

    assign ready_out = ready_r;
    assign valid_out = valid_r;
    assign q_out     = q_r;
    assign r_out     = r_r;
    assign op_out    = op_r;
    assign opb_out   = opb_r;
    assign x_out     = x_r;
    assign xb_out    = xb_r;
    assign a_out     = a_r;
    assign cb_out    = cb_r;

endmodule

// File: tb/tb_relm_div_seq.sv
// Testbench for relm_div_seq. It contains a behavioural radix-4 divide
// unit, which answers the sequencer's sub-op requests. It compares the
// results against plain N/D and N%D arithmetic. Latency and loop counts
// are derived from the msb positions of N and D.
module tb_relm_div_seq;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_in = 1'b0;
    logic          ready_out;
    logic [31:0]   n_in = 32'h0;
    logic [31:0]   den_in = 32'h0;
    logic          valid_out;
    logic          ack_in = 1'b0;
    logic [31:0]   q_out, r_out;
    logic [4:0]    op_out;
    logic          opb_out;
    logic [31:0]   x_out, xb_out, a_out;
    logic [95:0]   cb_out;
    logic [31:0]   a_in;
    logic [95:0]   cb_in;
    logic [31:0]   mul_a_in, mul_x_in;
    logic [63:0]   mul_ax_out;

    int errors = 0;
    int checks = 0;

    relm_div_seq #(.WD(32), .WOP(5), .WC(64)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .ready_out(ready_out),
        .n_in(n_in), .den_in(den_in), .valid_out(valid_out), .ack_in(ack_in),
        .q_out(q_out), .r_out(r_out), .op_out(op_out), .opb_out(opb_out),
        .x_out(x_out), .xb_out(xb_out), .a_out(a_out), .cb_out(cb_out),
        .a_in(a_in), .cb_in(cb_in), .mul_a_in(mul_a_in), .mul_x_in(mul_x_in),
        .mul_ax_out(mul_ax_out)
    );

    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic int msb_of(input logic [31:0] v);
        int m;
        m = -1;
        for (int i = 0; i < 32; i++) if (v[i]) m = i;
        return m;
    endfunction

    function automatic logic [31:0] onehot_msb(input logic [31:0] v);
        logic [31:0] r;
        r = 32'h0;
        if (v != 32'h0) r[msb_of(v)] = 1'b1;
        return r;
    endfunction

    // Expected DIVLOOP count: two quotient bits per iteration.
    function automatic int exp_loops(input logic [31:0] n, input logic [31:0] d);
        int mn, md;
        mn = msb_of(n);
        md = msb_of(d);
        if (d == 32'h0 || mn < md) return 0;
        return (mn - md) / 2 + 1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural custom divide unit ----------------
    // State layout: D field = running remainder, C field = shifted divisor,
    // B field = quotient so far, accumulator = current quotient digit weight.
    logic [31:0] u_df, u_cf, u_b, u_ptr;
    logic [1:0]  u_sel;
    logic        u_ok;
    logic [63:0] u_rem, u_c, u_t;

    assign {u_df, u_cf, u_b} = cb_out;
    assign u_sel = x_out[6:5];
    assign u_ok  = (op_out == 5'b00101);
    // Round the leading bit weight down to an even position.
    assign u_ptr = ((a_out & 32'h5555_5555) != 32'h0) ? a_out : (a_out >> 1);

    // Multiplier operands: divisor times starting digit weight.
    always_comb begin
        mul_a_in = 32'h0;
        mul_x_in = 32'h0;
        if (u_ok && opb_out && u_sel == 2'b01 && a_out != 32'h0) begin
            mul_a_in = u_cf;
            mul_x_in = u_ptr;
        end
    end

    // Sub-op responses.
    always_comb begin
        a_in  = 32'h0;
        cb_in = 96'h0;
        u_rem = 64'h0;
        u_c   = 64'h0;
        u_t   = 64'h0;
        if (u_ok && !opb_out) begin
            a_in  = onehot_msb(a_out);
            cb_in = {a_out, xb_out, onehot_msb(xb_out)};
        end else if (u_ok && u_sel == 2'b01) begin
            if (a_out == 32'h0) begin
                a_in  = 32'h0;
                cb_in = {u_df, u_cf, 32'h0};
            end else begin
                a_in  = u_ptr;
                cb_in = {u_df, mul_ax_out[31:0], 32'h0};
            end
        end else if (u_ok && u_sel == 2'b10) begin
            u_rem = {32'h0, u_df};
            u_c   = {32'h0, u_cf};
            if (u_rem >= 64'd3 * u_c)      u_t = 64'd3;
            else if (u_rem >= 64'd2 * u_c) u_t = 64'd2;
            else if (u_rem >= u_c)         u_t = 64'd1;
            else                           u_t = 64'd0;
            a_in  = a_out >> 2;
            cb_in = {32'(u_rem - u_t * u_c), u_cf >> 2, u_b + 32'(u_t * {32'h0, a_out})};
        end else if (u_ok && u_sel == 2'b11) begin
            a_in  = u_df;
            cb_in = cb_out;
        end
    end

    // ---------------- one request, start to acknowledge ----------------
    task automatic do_req(input logic [31:0] n, input logic [31:0] d, input int hold);
        int cnt, loops, act, bad, lat;
        logic [31:0] eq, er;
        eq  = (d == 32'h0) ? 32'hFFFF_FFFF : n / d;
        er  = (d == 32'h0) ? n : n % d;
        // Edges after the accepting edge until valid; a zero divisor is
        // presented in the cycle straight after the accept cycle.
        lat = (d == 32'h0) ? 0 : 3 + exp_loops(n, d);
        @(negedge clk);
        chk("ready_before", ready_out, 1);
        start_in = 1'b1;
        n_in     = n;
        den_in   = d;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
        n_in     = $urandom;
        den_in   = $urandom;
        cnt = 0; loops = 0; act = 0; bad = 0;
        while (!valid_out && cnt < 200) begin
            if (op_out != 5'h0 || opb_out || x_out != 32'h0) act++;
            if (op_out != 5'b00101) bad++;
            if ((x_out & 32'hFFFF_FF9F) != 32'h0) bad++;
            if (!opb_out && x_out != 32'h0) bad++;
            if (ready_out) bad++;
            if (opb_out && x_out[6:5] == 2'b10) loops++;
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        chk("latency", cnt, lat);
        chk("loop_cycles", loops, exp_loops(n, d));
        chk("active_cycles", act, (d == 32'h0) ? 0 : 3 + exp_loops(n, d));
        chk("encoding", bad, 0);
        chk("quotient", q_out, eq);
        chk("remainder", r_out, er);
        for (int i = 0; i < hold; i++) begin
            start_in = i[0];
            n_in     = $urandom;
            den_in   = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", valid_out, 1);
            chk("hold_ready", ready_out, 0);
            chk("hold_q", q_out, eq);
            chk("hold_r", r_out, er);
        end
        start_in = 1'b0;
        ack_in   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack_in = 1'b0;
        chk("valid_drop", valid_out, 0);
        chk("ready_back", ready_out, 1);
        chk("op_idle", {op_out, opb_out}, 0);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        logic [31:0] rn, rd;
        int w, guard;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", ready_out, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_qr", {q_out, r_out}, 0);
        chk("rst_op", {op_out, opb_out, x_out}, 0);
        chk("rst_state", {a_out, xb_out, cb_out}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        ack_in = 1'b1;
        do_req(32'd100, 32'd7, 0);
        do_req(32'hFFFF_FFFF, 32'd1, 0);
        do_req(32'd5, 32'd9, 0);
        do_req(32'd1234, 32'd0, 0);
        do_req(32'd0, 32'd17, 0);
        do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_req(32'h8000_0000, 32'd3, 0);

        do_req(32'd77777, 32'd13, 10);
        do_req(32'd81, 32'd9, 0);

        // Reset in the middle of the DIVLOOP phase.
        @(negedge clk);
        start_in = 1'b1;
        n_in     = 32'd1000;
        den_in   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_in = 1'b0;
        guard = 0;
        while (!(opb_out && x_out[6:5] == 2'b10) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_loop", guard < 20, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready_out, 1);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_qr", {q_out, r_out}, 0);
        chk("mid_rst_op", {op_out, opb_out, x_out}, 0);
        chk("mid_rst_state", {a_out, xb_out, cb_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(32'd1000, 32'd3, 0);

        for (int i = 0; i < 3000; i++) begin
            w  = $urandom_range(1, 32);
            rd = $urandom;
            if (w < 32) rd = rd & ((32'h1 << w) - 32'h1);
            rn = $urandom;
            if (i[2:0] == 3'd0) rn = rn & 32'h0000_FFFF;
            do_req(rn, rd, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
